// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM states, AXI burst/size encodings and default read IDs
package axi_arb_pkg;
  typedef enum logic {IDLE, ADDR} state_t;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [3:0] I_ID_DEF = 4'd0;
  localparam logic [3:0] D_ID_DEF = 4'd1;
endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: instruction/data read requesters plus AXI AR/R channels
interface axi_rd_arbiter_if;
  logic        i_rd_req, d_rd_req;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic [7:0]  i_rd_len, d_rd_len;
  logic [2:0]  i_rd_size, d_rd_size;
  logic        i_rd_addr_ok, d_rd_addr_ok;
  logic        i_rd_valid, d_rd_valid;
  logic [31:0] i_rd_data, d_rd_data;
  logic        i_rd_last, d_rd_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  modport master (
    input  i_rd_req, d_rd_req, i_rd_addr, d_rd_addr, i_rd_len, d_rd_len, i_rd_size, d_rd_size,
    output i_rd_addr_ok, d_rd_addr_ok, i_rd_valid, d_rd_valid, i_rd_data, d_rd_data, i_rd_last, d_rd_last,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    output i_rd_req, d_rd_req, i_rd_addr, d_rd_addr, i_rd_len, d_rd_len, i_rd_size, d_rd_size,
    input  i_rd_addr_ok, d_rd_addr_ok, i_rd_valid, d_rd_valid, i_rd_data, d_rd_data, i_rd_last, d_rd_last,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way arbiter, bit0=I bit1=D; round-robin with AXI_RD_ARB_ROUND_ROBIN_EN, else D-first fixed priority
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  // ptr_q holds the side granted last; 0 (I) after reset so D wins the first tie
  always_comb begin
    gnt = (&req) ? (ptr_q ? 2'b01 : 2'b10) : req;
    ptr_d = (|req) ? gnt[1] : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
`else
  logic unused;
  assign unused = ^{clk, reset};
  assign gnt = req[1] ? 2'b10 : req;
`endif
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: merges I/D read requesters onto one AXI read port, one outstanding burst per side
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [3:0] I_ID = I_ID_DEF,
  parameter logic [3:0] D_ID = D_ID_DEF
) (
  input logic clk,
  input logic reset,
  axi_rd_arbiter_if.master bus
);
  state_t      state_q, state_d;
  logic        i_out_q, i_out_d, d_out_q, d_out_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  req, gnt;
  logic        i_hit, d_hit, unused;
  // arbitration is suppressed during reset so no addr_ok can escape
  assign req = (state_q == IDLE && !reset) ?
               {bus.d_rd_req & ~d_out_q, bus.i_rd_req & ~i_out_q} : 2'b00;
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req(req), .gnt(gnt));
  always_comb begin
    i_hit = bus.rvalid && bus.rid == I_ID && i_out_q;
    d_hit = bus.rvalid && bus.rid == D_ID && d_out_q;
    state_d = state_q;
    arid_d = arid_q;
    araddr_d = araddr_q;
    arlen_d = arlen_q;
    arsize_d = arsize_q;
    i_out_d = i_out_q & ~(i_hit & bus.rlast);
    d_out_d = d_out_q & ~(d_hit & bus.rlast);
    if (|gnt) begin
      state_d = ADDR;
      arid_d = gnt[1] ? D_ID : I_ID;
      araddr_d = gnt[1] ? bus.d_rd_addr : bus.i_rd_addr;
      arlen_d = gnt[1] ? bus.d_rd_len : bus.i_rd_len;
      arsize_d = gnt[1] ? bus.d_rd_size : bus.i_rd_size;
    end else if (state_q == ADDR && bus.arready) begin
      state_d = IDLE;
      i_out_d = i_out_d | (arid_q != D_ID);
      d_out_d = d_out_d | (arid_q == D_ID);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_out_q <= 1'b0;
      d_out_q <= 1'b0;
      arid_q <= '0;
      araddr_q <= '0;
      arlen_q <= '0;
      arsize_q <= '0;
    end else begin
      state_q <= state_d;
      i_out_q <= i_out_d;
      d_out_q <= d_out_d;
      arid_q <= arid_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      arsize_q <= arsize_d;
    end
  end
  assign bus.i_rd_addr_ok = gnt[0];
  assign bus.d_rd_addr_ok = gnt[1];
  assign bus.arvalid = state_q == ADDR;
  assign bus.arid = arid_q;
  assign bus.araddr = araddr_q;
  assign bus.arlen = arlen_q;
  assign bus.arsize = arsize_q;
  assign bus.arburst = BURST_INCR;
  assign bus.arlock = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot = 3'b000;
  assign bus.rready = 1'b1;
  assign bus.i_rd_valid = i_hit;
  assign bus.i_rd_data = bus.rdata;
  assign bus.i_rd_last = i_hit & bus.rlast;
  assign bus.d_rd_valid = d_hit;
  assign bus.d_rd_data = bus.rdata;
  assign bus.d_rd_last = d_hit & bus.rlast;
  assign unused = ^bus.rresp;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: table-driven bursts plus hand-written tie/stall/hold/stray/reset sequences
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;
  localparam logic [3:0] IID = 4'd0;
  localparam logic [3:0] DID = 4'd1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  axi_rd_arbiter_if bus();
  axi_rd_arbiter #(.I_ID(IID), .D_ID(DID)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {logic side; logic [31:0] data; logic last;} beat_t;
  typedef struct {logic side; logic [31:0] addr; logic [7:0] len; logic [2:0] size; int low; logic [3:0] exp_arid;} vec_t;
  beat_t sb[$];
  vec_t tbl[5];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic drive_req(input logic side, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    if (side) begin
      bus.d_rd_req = 1'b1; bus.d_rd_addr = addr; bus.d_rd_len = len; bus.d_rd_size = size;
    end else begin
      bus.i_rd_req = 1'b1; bus.i_rd_addr = addr; bus.i_rd_len = len; bus.i_rd_size = size;
    end
  endtask
  task automatic drop_req(input logic side);
    if (side) bus.d_rd_req = 1'b0;
    else bus.i_rd_req = 1'b0;
  endtask
  task automatic wait_grant(input logic side, input string name, output int cyc);
    cyc = -1;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (side ? bus.d_rd_addr_ok : bus.i_rd_addr_ok) begin
        cyc = k;
        break;
      end
      step();
    end
    chk({name, "_ok"}, 32'(cyc >= 0), 32'd1);
    chk({name, "_other_ok"}, 32'(side ? bus.i_rd_addr_ok : bus.d_rd_addr_ok), 32'd0);
  endtask
  task automatic ar_hs(input int low, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    for (int s = 0; s < low; s++) begin
      smp();
      chk("ar_valid", 32'(bus.arvalid), 32'd1);
      chk("ar_addr", bus.araddr, addr);
      chk("ar_id", 32'(bus.arid), 32'(id));
      chk("ar_no_ok", 32'({bus.i_rd_addr_ok, bus.d_rd_addr_ok}), 32'd0);
      if (s == 0) begin
        chk("ar_len", 32'(bus.arlen), 32'(len));
        chk("ar_size", 32'(bus.arsize), 32'(size));
        chk("ar_burst", 32'(bus.arburst), 32'd1);
        chk("ar_attr", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
      end
      step();
    end
    bus.arready = 1'b1;
    smp();
    chk("ar_hs_valid", 32'(bus.arvalid), 32'd1);
    step();
    bus.arready = 1'b0;
  endtask
  task automatic take(input logic side, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input int low, input string name, output int cyc);
    wait_grant(side, name, cyc);
    step();
    drop_req(side);
    ar_hs(low, side ? DID : IID, addr, len, size);
  endtask
  // exp_side: 0 = discard, 1 = I, 2 = D; exp_ok = expected {d,i} addr_ok during the beat
  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last, input int exp_side, input logic [1:0] exp_ok);
    beat_t e;
    bus.rvalid = 1'b1; bus.rid = id; bus.rdata = data; bus.rlast = last;
    bus.rresp = 2'b10;
    if (exp_side != 0) sb.push_back('{exp_side == 2, data, last});
    smp();
    if (bus.i_rd_valid || bus.d_rd_valid) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r_unexpected: got i_valid=%b d_valid=%b expected none", bus.i_rd_valid, bus.d_rd_valid);
      end else begin
        e = sb.pop_front();
        chk("r_one_side", 32'(bus.i_rd_valid & bus.d_rd_valid), 32'd0);
        chk("r_side", 32'(bus.d_rd_valid), 32'(e.side));
        chk("r_data", e.side ? bus.d_rd_data : bus.i_rd_data, e.data);
        chk("r_last", 32'(e.side ? bus.d_rd_last : bus.i_rd_last), 32'(e.last));
      end
    end else begin
      chk("r_missing", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    chk("r_ready", 32'(bus.rready), 32'd1);
    chk("r_ok", 32'({bus.d_rd_addr_ok, bus.i_rd_addr_ok}), 32'(exp_ok));
    step();
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic w;
    tbl[0] = '{1'b0, 32'h1FC0_0000, 8'd3, SIZE_4B, 1, IID};
    tbl[1] = '{1'b1, 32'h8000_1000, 8'd0, SIZE_4B, 2, DID};
    tbl[2] = '{1'b0, 32'h0000_0040, 8'd7, SIZE_2B, 1, IID};
    tbl[3] = '{1'b1, 32'hFFFF_FFFC, 8'd1, SIZE_1B, 5, DID};
    tbl[4] = '{1'b1, 32'h1234_5678, 8'd2, SIZE_4B, 3, DID};
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.i_rd_addr = 0; bus.d_rd_addr = 0;
    bus.i_rd_len = 0; bus.d_rd_len = 0; bus.i_rd_size = 0; bus.d_rd_size = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    // reset: a request during reset must not be acknowledged
    repeat (3) step();
    bus.d_rd_req = 1'b1;
    smp();
    chk("rst_no_ok", 32'({bus.i_rd_addr_ok, bus.d_rd_addr_ok}), 32'd0);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    step();
    reset = 1'b0;
    bus.d_rd_req = 1'b0;
    smp();
    chk("post_rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("post_rst_ok", 32'({bus.i_rd_addr_ok, bus.d_rd_addr_ok}), 32'd0);
    chk("post_rst_rready", 32'(bus.rready), 32'd1);
    step();
    // tie right after reset: D first, I granted the cycle after D's handshake
    drive_req(1'b0, 32'hA000_0000, 8'd0, SIZE_4B);
    drive_req(1'b1, 32'hB000_0000, 8'd0, SIZE_4B);
    take(1'b1, 32'hB000_0000, 8'd0, SIZE_4B, 1, "tie1_d", cyc);
    chk("tie1_d_lat", 32'(cyc), 32'd0);
    take(1'b0, 32'hA000_0000, 8'd0, SIZE_4B, 1, "tie1_i", cyc);
    chk("tie1_i_lat", 32'(cyc), 32'd0);
    beat(DID, 32'hD000_0001, 1'b1, 2, 2'b00);
    beat(IID, 32'h1000_0001, 1'b1, 1, 2'b00);
    // table of single-requester bursts
    for (int v = 0; v < 5; v++) begin
      drive_req(tbl[v].side, tbl[v].addr, tbl[v].len, tbl[v].size);
      take(tbl[v].side, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].low, "tbl", cyc);
      chk("tbl_lat", 32'(cyc), 32'd0);
      for (int b = 0; b <= int'(tbl[v].len); b++)
        beat(tbl[v].exp_arid, 32'hC0DE_0000 + 32'(v << 8) + 32'(b), b == int'(tbl[v].len),
             tbl[v].side ? 2 : 1, 2'b00);
    end
    // tie after a D grant: round-robin picks I, fixed priority picks D
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    drive_req(1'b0, 32'hA100_0000, 8'd0, SIZE_4B);
    drive_req(1'b1, 32'hB100_0000, 8'd0, SIZE_4B);
    take(w, w ? 32'hB100_0000 : 32'hA100_0000, 8'd0, SIZE_4B, 1, "tie2_win", cyc);
    take(~w, w ? 32'hA100_0000 : 32'hB100_0000, 8'd0, SIZE_4B, 1, "tie2_lose", cyc);
    beat(IID, 32'h1000_0002, 1'b1, 1, 2'b00);
    beat(DID, 32'hD000_0002, 1'b1, 2, 2'b00);
    // I request held while its burst is outstanding
    drive_req(1'b0, 32'h0000_1000, 8'd1, SIZE_4B);
    take(1'b0, 32'h0000_1000, 8'd1, SIZE_4B, 1, "hold_a", cyc);
    drive_req(1'b0, 32'h0000_2000, 8'd0, SIZE_4B);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("hold_no_ok", 32'(bus.i_rd_addr_ok), 32'd0);
      step();
    end
    beat(IID, 32'h1000_0010, 1'b0, 1, 2'b00);
    beat(IID, 32'h1000_0011, 1'b1, 1, 2'b00);
    take(1'b0, 32'h0000_2000, 8'd0, SIZE_4B, 1, "hold_b", cyc);
    chk("hold_b_lat", 32'(cyc), 32'd0);
    // D rlast in the same cycle I becomes eligible: I grant proceeds (I still outstanding from hold_b first)
    beat(IID, 32'h1000_0012, 1'b1, 1, 2'b00);
    drive_req(1'b1, 32'h0000_3000, 8'd0, SIZE_4B);
    take(1'b1, 32'h0000_3000, 8'd0, SIZE_4B, 1, "same_d", cyc);
    drive_req(1'b0, 32'h0000_4000, 8'd0, SIZE_4B);
    beat(DID, 32'hD000_0003, 1'b1, 2, 2'b01);
    drop_req(1'b0);
    ar_hs(1, IID, 32'h0000_4000, 8'd0, SIZE_4B);
    // stray beats: unknown id, then D id with nothing outstanding on D
    beat(4'd7, 32'hBAD0_0007, 1'b1, 0, 2'b00);
    beat(DID, 32'hBAD0_0001, 1'b1, 0, 2'b00);
    beat(IID, 32'h1000_0013, 1'b1, 1, 2'b00);
    // reset while in ADDR with D outstanding
    drive_req(1'b1, 32'h0000_5000, 8'd0, SIZE_4B);
    take(1'b1, 32'h0000_5000, 8'd0, SIZE_4B, 1, "rst_d", cyc);
    drive_req(1'b0, 32'h0000_6000, 8'd0, SIZE_4B);
    wait_grant(1'b0, "rst_i", cyc);
    step();
    drop_req(1'b0);
    smp();
    chk("rst_pre_arvalid", 32'(bus.arvalid), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    smp();
    chk("rst_mid_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_mid_araddr", bus.araddr, 32'd0);
    step();
    beat(IID, 32'hBAD0_0000, 1'b1, 0, 2'b00);
    beat(DID, 32'hBAD0_0011, 1'b1, 0, 2'b00);
    drive_req(1'b1, 32'h0000_7000, 8'd0, SIZE_4B);
    take(1'b1, 32'h0000_7000, 8'd0, SIZE_4B, 1, "rst_after", cyc);
    chk("rst_after_lat", 32'(cyc), 32'd0);
    beat(DID, 32'hD000_0004, 1'b1, 2, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
